// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and port owner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Plain 2-input multiplexer: sel_i=0 picks in0_i, sel_i=1 picks in1_i.
module mem_port_arbiter_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  output logic [WIDTH-1:0] out_o
);

  // Select between the two inputs
  always_comb begin
    out_o = sel_i ? in1_i : in0_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I)
// and load/store (D). One transaction outstanding at a time; the payload is
// latched at grant and held until the memory acknowledges.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_sel
);

  state_e                  state_q, state_d;
  owner_e                  last_grant_q, last_grant_d;
  owner_e                  mem_sel_q, mem_sel_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  owner_e                  win;
  logic                    any_req;
  logic [ADDR_WIDTH-1:0]   win_addr;

  // Combinational winner: D wins only if I is idle or I had the last grant
  always_comb begin
    any_req = i_req | d_req;
    win     = OWN_I;
    if (d_req && (!i_req || (last_grant_q == OWN_I))) begin
      win = OWN_D;
    end
  end

  mem_port_arbiter_mux #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_mux (
    .sel_i (win == OWN_D),
    .in0_i (i_addr),
    .in1_i (d_addr),
    .out_o (win_addr)
  );

  // Next-state and payload latching; payload only changes on a grant
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_sel_d    = mem_sel_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = (win == OWN_D) ? BUSY_D : BUSY_I;
          last_grant_d = win;
          mem_sel_d    = win;
          mem_req_d    = 1'b1;
          mem_addr_d   = win_addr;
          // Fetches never write; their write-data slot is parked at zero
          mem_we_d     = (win == OWN_D) & d_we;
          mem_wdata_d  = (win == OWN_D) ? d_wdata : '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and payload registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_D;
      mem_sel_q    <= OWN_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_sel_q    <= mem_sel_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Acks follow mem_ack in the same cycle, routed to the current owner only
  always_comb begin
    i_ack     = (state_q == BUSY_I) & mem_ack;
    d_ack     = (state_q == BUSY_D) & mem_ack;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_sel   = mem_sel_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Drives the select of the shared address/data MUX (mem_sel) and routes each response back to the requester that owns the transaction.
- Arbitration is round-robin. Transactions are latched, and only one is outstanding at a time.
- Sits between the IF/MEM stages and the single-ported memory.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in the same cycle.
- i_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  one-cycle pulse; d_rdata is valid in the same cycle (loads only).
- d_rdata  out  DATA_WIDTH  load data.
- mem_req  out  1  request to memory; held high until mem_ack.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_ack  in  1  memory completion pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read data from memory.
- mem_sel  out  1  owner of the port: 0 = I, 1 = D.

Behaviour:
- Reset (clk edge with rst=1) sets:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=0;
  - last_grant=D, so I wins the first tie;
  - i_ack=0, d_ack=0.
- rdata outputs are combinational copies of mem_rdata. They are only meaningful while the matching ack is high.
- States:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- IDLE transitions:
  - Only i_req=1: go to BUSY_I.
  - Only d_req=1: go to BUSY_D.
  - Both high: grant the requester that is not last_grant.
  - Neither high: stay in IDLE.
- On a grant edge:
  - The winner's addr, wdata and we are latched into the mem_* registers (we forced to 0 for I).
  - mem_req is set to 1, mem_sel is set to the winner, and last_grant is set to the winner.
- BUSY_x:
  - mem_req and the mem_* payload stay stable regardless of requester inputs.
  - On mem_ack=1: x_ack=1 combinationally in the same cycle; at the edge, mem_req goes to 0 and state goes to IDLE.
  - mem_sel keeps its value until the next grant.
- Latency:
  - Request first seen high at cycle N gives mem_req high at cycle N+1 at the earliest.
  - Requester ack arrives in the same cycle as mem_ack.
  - One mandatory IDLE cycle follows each ack before the next grant.
  - Back-to-back throughput is therefore one transaction per (mem latency + 2) cycles.
- Requester protocol:
  - req and payload are held until ack.
  - The requester drops req in the cycle after ack, or keeps it high to issue a new request. A held req counts as a new request in the following IDLE cycle.
  - If req drops mid-transaction, the transaction still completes and the ack is still issued.
- Spurious input: mem_ack while in IDLE is ignored; neither ack is generated.
- Same-cycle mem_ack and new req: the ack goes to the current owner. The new request is arbitrated in the next IDLE cycle.
- Starvation: a requester with req held continuously waits at most one transaction of the other requester.
- Reset mid-transaction:
  - Abandons the transaction: mem_req=0 on that edge, and no ack is generated.
  - The memory side must also be reset.
- Width: all buses pass straight through; there is no resizing or byte-strobe logic.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - the owner encoding (OWN_I=1'b0, OWN_D=1'b1).
- Sub-module: the existing 2-input MUX module, instantiated with WIDTH=ADDR_WIDTH. Inputs are i_addr and d_addr, selected by the combinational winner, feeding the mem_addr register.
- All other logic is inline.

Test Plan:
- Reset then single fetch:
  - Stimulus: rst high for 2 cycles; i_req=1, i_addr=0x0000_1000; memory acks 3 cycles after mem_req with rdata 0xDEAD_BEEF.
  - Required: mem_req rises at cycle 1; mem_addr=0x1000, mem_we=0, mem_sel=0; i_ack pulses once with i_rdata=0xDEAD_BEEF; d_ack stays 0.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x1234_5678.
  - Required: mem_we=1, mem_addr=0x2004, mem_wdata=0x1234_5678, mem_sel=1; d_ack pulses once.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req both held high continuously.
  - Required: grant order I, D, I, D; each grant is separated from the previous ack by exactly one IDLE cycle.
- Payload stability:
  - Stimulus: during BUSY_D, change d_addr to 0xFFFF_0000 and drop d_req.
  - Required: mem_addr stays 0x2004, and d_ack still pulses.
- Spurious ack:
  - Stimulus: pulse mem_ack while in IDLE with no requests.
  - Required: no i_ack or d_ack, and state stays IDLE.
- Reset mid-transaction:
  - Stimulus: assert rst during BUSY_I, before mem_ack.
  - Required: mem_req=0 on the next edge, no i_ack, mem_sel=0; a following d_req is then served normally.
